// File: rtl/gpu_irq_ctrl_pkg.sv
// gpu_irq_ctrl_pkg
// Shared constants for the GPU interrupt/status controller: the register
// address map and the bit position of each interrupt source inside the
// PENDING and ENABLE registers.
package gpu_irq_ctrl_pkg;

    // Register addresses
    localparam int REG_STATUS        = 0;
    localparam int REG_PENDING       = 1;
    localparam int REG_ENABLE        = 2;
    localparam int REG_SCANLINE      = 3;
    localparam int REG_LINE_CMP_BASE = 4;

    // Interrupt source bit indices
    localparam int SRC_VBL_START = 0;
    localparam int SRC_VBL_END   = 1;
    localparam int SRC_LINE_BASE = 2;

    // Number of source bits used for a given count of compare channels
    function automatic int num_sources(input int num_line_cmp);
        return SRC_LINE_BASE + num_line_cmp;
    endfunction

endpackage

// File: rtl/gpu_line_cmp_m.sv
// gpu_line_cmp_m
// One scanline-compare channel. Holds an 8-bit compare value, compares it
// against the current scanline and emits a single-cycle event on the
// rising edge of the match.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   primed      low for the first clock after reset; suppresses events
//   scanline    current scanline
//   wr          load strobe for the compare value
//   wr_data     new compare value
//   cmp_val     current compare value (for register readback)
//   evt         match rising-edge event
module gpu_line_cmp_m
    import gpu_irq_ctrl_pkg::*;
#(
    parameter int SCAN_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              primed,
    input  logic [SCAN_W-1:0] scanline,
    input  logic              wr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        cmp_val,
    output logic              evt
);

    logic [7:0] cmp_q;
    logic       hist_q;
    logic       match_cur;
    logic       match_new;

    // Compare values are zero-extended, so only lines 0..255 can match.
    assign match_cur = (scanline == SCAN_W'(cmp_q));
    assign match_new = (scanline == SCAN_W'(wr_data));

    // The event is judged against the compare value in force this cycle.
    assign evt     = primed & match_cur & ~hist_q;
    assign cmp_val = cmp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q  <= '0;
            hist_q <= 1'b0;
        end else begin
            if (wr) begin
                cmp_q <= wr_data;
            end
            // On a compare write the history takes the match result for the
            // new value, so writing the current scanline does not fire.
            hist_q <= wr ? match_new : match_cur;
        end
    end

endmodule

// File: rtl/gpu_irq_ctrl.sv
// gpu_irq_ctrl
// Interrupt and status controller for the GPU, mapped on the CPU data bus.
// Sources: VBLANK start, VBLANK end and NUM_LINE_CMP scanline compares.
// Each source has a pending bit (W1C), an enable bit, and all enabled
// pending bits are ORed into a registered level interrupt.
//
// Ports:
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   vcounter      vertical counter from video timing
//   writable      high while in VBLANK
//   data          bidirectional 8-bit CPU data bus
//   reg_addr      register select
//   write_enable  CPU write strobe
//   select        block chip-select
//   irq           registered interrupt request, active high
module gpu_irq_ctrl
    import gpu_irq_ctrl_pkg::*;
#(
    parameter int VCOUNT_WIDTH   = 10,
    parameter int LINE_SHIFT     = 1,
    parameter int NUM_LINE_CMP   = 2,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [VCOUNT_WIDTH-1:0]   vcounter,
    input  logic                      writable,
    inout  wire  [7:0]                data,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic                      write_enable,
    input  logic                      select,
    output logic                      irq
);

    localparam int NP     = num_sources(NUM_LINE_CMP);
    localparam int SCAN_W = VCOUNT_WIDTH - LINE_SHIFT;

    localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS   = REG_ADDR_WIDTH'(REG_STATUS);
    localparam logic [REG_ADDR_WIDTH-1:0] A_PENDING  = REG_ADDR_WIDTH'(REG_PENDING);
    localparam logic [REG_ADDR_WIDTH-1:0] A_ENABLE   = REG_ADDR_WIDTH'(REG_ENABLE);
    localparam logic [REG_ADDR_WIDTH-1:0] A_SCANLINE = REG_ADDR_WIDTH'(REG_SCANLINE);

    logic [SCAN_W-1:0]       scanline;
    logic [15:0]             scan_ext;
    logic                    primed;
    logic                    writable_q;
    logic [NP-1:0]           pending;
    logic [NP-1:0]           enable;
    logic [NP-1:0]           evt;
    logic [NP-1:0]           w1c_mask;
    logic [NUM_LINE_CMP-1:0] line_evt;
    logic [NUM_LINE_CMP-1:0] line_wr;
    logic [7:0]              cmp_val [NUM_LINE_CMP];
    logic                    bus_wr;
    logic                    vbl_start;
    logic                    vbl_end;
    logic [7:0]              rdata;
    logic [7:0]              wdata;

    assign scanline = vcounter[VCOUNT_WIDTH-1:LINE_SHIFT];
    assign scan_ext = 16'(scanline);
    assign wdata    = data;
    assign bus_wr   = select & write_enable;

    assign vbl_start = primed &  writable & ~writable_q;
    assign vbl_end   = primed & ~writable &  writable_q;
    assign evt       = {line_evt, vbl_end, vbl_start};

    assign w1c_mask = (bus_wr && reg_addr == A_PENDING) ? wdata[NP-1:0] : '0;

    generate
        for (genvar k = 0; k < NUM_LINE_CMP; k++) begin : g_line
            assign line_wr[k] = bus_wr &&
                (reg_addr == REG_ADDR_WIDTH'(REG_LINE_CMP_BASE + k));

            gpu_line_cmp_m #(
                .SCAN_W (SCAN_W)
            ) u_line_cmp (
                .clk      (clk),
                .rst_n    (rst_n),
                .primed   (primed),
                .scanline (scanline),
                .wr       (line_wr[k]),
                .wr_data  (wdata),
                .cmp_val  (cmp_val[k]),
                .evt      (line_evt[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed     <= 1'b0;
            writable_q <= 1'b0;
            pending    <= '0;
            enable     <= '0;
            irq        <= 1'b0;
        end else begin
            primed     <= 1'b1;
            writable_q <= writable;
            // Set wins over a same-cycle clear so no event is lost.
            pending    <= (pending & ~w1c_mask) | evt;
            if (bus_wr && reg_addr == A_ENABLE) begin
                enable <= wdata[NP-1:0];
            end
            irq <= |(pending & enable);
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (reg_addr == A_STATUS) begin
            rdata = {6'b0, scan_ext[8], writable};
        end else if (reg_addr == A_PENDING) begin
            rdata = 8'(pending);
        end else if (reg_addr == A_ENABLE) begin
            rdata = 8'(enable);
        end else if (reg_addr == A_SCANLINE) begin
            rdata = scan_ext[7:0];
        end else begin
            for (int k = 0; k < NUM_LINE_CMP; k++) begin
                if (reg_addr == REG_ADDR_WIDTH'(REG_LINE_CMP_BASE + k)) begin
                    rdata = cmp_val[k];
                end
            end
        end
    end

    assign data = (select && !write_enable) ? rdata : 8'bz;

endmodule

// File: tb/tb_gpu_irq_ctrl.sv
// tb_gpu_irq_ctrl
// Directed bench for gpu_irq_ctrl with hand-computed expected values.
module tb_gpu_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] vcounter;
    logic       writable;
    wire  [7:0] data;
    logic [2:0] reg_addr;
    logic       write_enable;
    logic       select;
    logic       irq;

    logic       drv_en;
    logic [7:0] drv_val;
    logic [7:0] rd;

    int n_cmp = 0;
    int n_err = 0;

    assign data = drv_en ? drv_val : 8'bz;

    gpu_irq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vcounter     (vcounter),
        .writable     (writable),
        .data         (data),
        .reg_addr     (reg_addr),
        .write_enable (write_enable),
        .select       (select),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [7:0] val);
        reg_addr     = addr;
        select       = 1'b1;
        write_enable = 1'b1;
        drv_val      = val;
        drv_en       = 1'b1;
        tick();
        select       = 1'b0;
        write_enable = 1'b0;
        drv_en       = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [7:0] val);
        reg_addr     = addr;
        select       = 1'b1;
        write_enable = 1'b0;
        #1;
        val    = data;
        select = 1'b0;
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        vcounter     = 10'd0;
        writable     = 1'b1;
        reg_addr     = 3'd0;
        write_enable = 1'b0;
        select       = 1'b0;
        drv_en       = 1'b0;
        drv_val      = 8'h00;

        // Reset with writable held high, then release
        tick();
        tick();
        check("reset_irq", irq, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("primed_irq_low", irq, 0);
        end
        bus_read(3'd1, rd); check("primed_pending", rd, 8'h00);
        bus_read(3'd0, rd); check("status_vblank", rd, 8'h01);

        // VBLANK end (unmasked) then clear it, set up VBLANK start test
        writable = 1'b0;
        tick();
        bus_read(3'd1, rd); check("vbl_end_pending", rd, 8'h02);
        bus_write(3'd1, 8'h02);
        bus_read(3'd1, rd); check("w1c_bit1", rd, 8'h00);
        bus_write(3'd2, 8'h01);
        bus_read(3'd2, rd); check("enable_rb", rd, 8'h01);
        writable = 1'b1;
        tick();
        bus_read(3'd1, rd); check("vbl_start_pending", rd, 8'h01);
        check("vbl_start_irq_E", irq, 0);
        tick();
        check("vbl_start_irq_E1", irq, 1);
        bus_write(3'd1, 8'h01);
        tick();
        check("w1c_irq_drop", irq, 0);

        // Scanline compare channel 0 at line 100
        bus_write(3'd4, 8'h64);
        bus_write(3'd2, 8'h04);
        vcounter = 10'd199;
        tick();
        bus_read(3'd1, rd); check("line_before", rd, 8'h00);
        vcounter = 10'd200;
        tick();
        bus_read(3'd1, rd); check("line_pending", rd, 8'h04);
        tick();
        check("line_irq", irq, 1);
        vcounter = 10'd201;
        tick();
        tick();
        check("line_irq_hold", irq, 1);
        bus_read(3'd3, rd); check("scanline_rb", rd, 8'h64);
        bus_read(3'd4, rd); check("line_cmp0_rb", rd, 8'h64);
        bus_write(3'd1, 8'h04);
        tick();
        check("line_w1c_irq", irq, 0);
        bus_read(3'd1, rd); check("line_no_refire", rd, 8'h00);

        // Masked VBLANK end, then enable it
        bus_write(3'd2, 8'h00);
        writable = 1'b0;
        tick();
        tick();
        bus_read(3'd1, rd); check("masked_pending", rd, 8'h02);
        check("masked_irq", irq, 0);
        bus_write(3'd2, 8'h02);
        check("enable_irq_same", irq, 0);
        tick();
        check("enable_irq_late", irq, 1);
        bus_write(3'd1, 8'h02);
        tick();
        check("vbl_end_clear_irq", irq, 0);

        // W1C of bit0 in the same cycle as VBLANK start: set wins
        writable = 1'b1;
        bus_write(3'd1, 8'h01);
        bus_read(3'd1, rd); check("set_wins", rd, 8'h01);
        bus_write(3'd1, 8'h01);
        bus_read(3'd1, rd); check("w1c_after", rd, 8'h00);

        // Write LINE_CMP[1] equal to the current scanline (100): no event
        bus_write(3'd5, 8'h64);
        tick();
        tick();
        bus_read(3'd1, rd); check("cmp_write_no_evt", rd, 8'h00);
        bus_read(3'd5, rd); check("line_cmp1_rb", rd, 8'h64);

        // Unmapped address reads 0 and ignores writes
        bus_write(3'd7, 8'hFF);
        bus_read(3'd7, rd); check("unmapped", rd, 8'h00);

        // Mid-frame asynchronous reset with irq high
        writable = 1'b0;
        tick();
        tick();
        check("pre_reset_irq", irq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_irq", irq, 0);
        bus_read(3'd1, rd); check("async_pending", rd, 8'h00);
        bus_read(3'd2, rd); check("async_enable", rd, 8'h00);
        bus_read(3'd4, rd); check("async_line_cmp", rd, 8'h00);
        writable = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        bus_read(3'd1, rd); check("reprimed_pending", rd, 8'h00);

        // STATUS scanline bit 8 and SCANLINE low byte at line 300
        vcounter = 10'd600;
        tick();
        bus_read(3'd0, rd); check("status_line_msb", rd, 8'h03);
        bus_read(3'd3, rd); check("scanline_300", rd, 8'h2C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpu_irq_ctrl.md
Name:
gpu_irq_ctrl

Overview:
- Parametrised interrupt and status controller for the GPU, memory-mapped on the CPU data bus beside VRAM.
- Generalises the single VBLANK interrupt to several sources:
  - VBLANK start
  - VBLANK end
  - NUM_LINE_CMP programmable scanline-compare channels
- Each source has a pending bit, an enable mask bit and write-1-to-clear acknowledge.
- Exposes live in-VBLANK status and the current scanline, and drives one level interrupt output to the CPU.

Parameters:
- VCOUNT_WIDTH, 10, width of the vertical counter from video timing.
- LINE_SHIFT, 1, right shift from vcounter to scanline (1 = line-doubled 240p).
- NUM_LINE_CMP, 2, number of scanline-compare channels; legal range 1..4.
- REG_ADDR_WIDTH, 3, register address width.

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst_n  in  1  asynchronous, active-low reset
- vcounter  in  VCOUNT_WIDTH  vertical counter from video timing
- writable  in  1  high while in VBLANK (VRAM writable)
- data  inout  8  CPU data bus
- reg_addr  in  REG_ADDR_WIDTH  register select
- write_enable  in  1  CPU write strobe
- select  in  1  block chip-select
- irq  out  1  registered interrupt request, active high

Behaviour:
- Reset is asynchronous, active-low. On reset, clear all of the following to 0:
  - pending[], enable[], line_cmp[]
  - irq
  - all edge-detect history registers
  - primed
- scanline = vcounter >> LINE_SHIFT, width VCOUNT_WIDTH-LINE_SHIFT (9 bits by default).
- Source index:
  - bit0 = VBLANK start (rising edge of writable)
  - bit1 = VBLANK end (falling edge of writable)
  - bit 2+k = rising edge of (scanline == {0, line_cmp[k]})
  - Compare values are 8 bits, so only lines 0..255 can match.
- The primed flag goes to 1 on the first clock after reset. While primed = 0:
  - history registers load the current inputs;
  - no events are generated.
  - This prevents spurious events right after reset.
- Event detected at clock edge E sets the pending bit at edge E. irq follows as irq <= |(pending & enable), so irq is high at edge E+1 (one-cycle latency).
- Events set pending regardless of enable. Enabling a source that is already pending raises irq one cycle after the write.
- Register map (NP = 2+NUM_LINE_CMP bits used):
  - 0 STATUS (R): [0] writable, [1] scanline[8], rest 0.
  - 1 PENDING (R / W1C): [NP-1:0] pending; writing 1 clears that bit, writing 0 has no effect.
  - 2 ENABLE (RW): [NP-1:0] mask; unused bits read 0.
  - 3 SCANLINE (R): scanline[7:0].
  - 4+k LINE_CMP[k] (RW), k < NUM_LINE_CMP.
  - All other addresses read 0 and ignore writes.
- Bus writes take effect on the clock edge where select && write_enable.
- Reads:
  - data is driven combinationally when select && !write_enable; otherwise data is high-Z.
  - Reads have no side effects.
- A same-cycle event and W1C on the same bit leaves the bit set (set wins; no event is lost).
- Writing LINE_CMP[k] equal to the current scanline must not fire an event: the channel's history register loads the new match result in the same cycle.
- A mid-frame reset returns everything to the reset state, and the primed sequence repeats.

Decomposition:
- Shared package holds:
  - register address constants (REG_STATUS, REG_PENDING, REG_ENABLE, REG_SCANLINE, REG_LINE_CMP_BASE)
  - source bit indices (SRC_VBL_START, SRC_VBL_END, SRC_LINE_BASE)
- One natural sub-module, gpu_line_cmp_m, instantiated NUM_LINE_CMP times. It contains one compare register, the match comparator, the history register and the event output.

Test Plan:
- Reset with writable=1 held, then release: no pending bit set; irq=0 for 10 cycles; STATUS reads 0x01.
- ENABLE=0x01, writable rises at edge E: PENDING=0x01 at E; irq=1 at E+1. Write PENDING=0x01: irq=0 on the next cycle.
- LINE_CMP[0]=100 (0x64), ENABLE=0x04: as vcounter goes 199->200, PENDING bit2 is set. irq stays high through vcounter 201 (the next odd count) until W1C. SCANLINE reads 0x64.
- ENABLE=0x00 with VBLANK end occurring: PENDING=0x02, irq=0. Then write ENABLE=0x02: irq=1 one cycle later.
- Assert W1C of bit0 in the same cycle as a VBLANK-start edge: PENDING bit0 remains 1.
- Write LINE_CMP[1]=current scanline: no event. Assert rst_n=0 mid-frame with irq=1: irq, PENDING and ENABLE read 0 immediately (asynchronous).
